fsa_bank_ctl: RTL and testbench
===============================

# fsa_bank_ctl

Bank scheduler for the frame-statistics line-buffer banks. Each frame it picks one free bank for the statistics core to write, driving the core's one-hot write-bank select. It queues completed banks in frame order and hands them one at a time to a downstream result reader through a valid/ready grant and release handshake. Sits between the video input timing and the statistics core on one side and the result reader on the other.

## Interface
- BR_NUM, 4, number of result banks (2..8)
- BR_IW, 2, bank index width, ≥ clog2(BR_NUM)
- C_CNT_W, 16, width of the frame, drop and abort counters

- clk  in  1  clock; everything is synchronous to its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  allow new bank allocation at frame start
- frame_start  in  1  one-cycle pulse on the first accepted pixel of a frame (tvalid & tuser)
- core_eof  in  1  one-cycle pulse from the core when the last window pixel has been written
- wr_bmp  out  BR_NUM  one-hot write-bank select to the core; all-zero means the frame is not captured
- res_valid  out  1  a FULL bank is offered to the reader
- res_idx  out  BR_IW  index of the offered bank; valid while res_valid
- res_ready  in  1  reader accepts the offered bank
- rd_bmp  out  BR_NUM  one-hot bank currently being read; drives the read mux
- res_release  in  1  one-cycle pulse; reader has finished with the READING bank
- frame_cnt  out  C_CNT_W  frames captured, saturating
- drop_cnt  out  C_CNT_W  frames not captured because enable was low or no bank was free, saturating
- abort_cnt  out  C_CNT_W  FILLING banks discarded because the next frame_start arrived before core_eof, saturating
- err  out  1  sticky protocol error flag

## Operation
- Per-bank state: FREE → FILLING → FULL → READING → FREE.
  - At most one bank is FILLING.
  - At most one bank is READING.
- Order FIFO: depth BR_NUM, holds FULL bank indices, oldest first.
- Each cycle, events are applied in this order: release, eof, frame_start.
- **Release**
  - res_release with a READING bank: that bank goes to FREE and rd_bmp clears.
  - res_release with no READING bank: ignored, err set.
- **EOF**
  - core_eof with a FILLING bank: the bank goes to FULL, its index is pushed to the FIFO, frame_cnt increments.
  - core_eof with no FILLING bank: ignored, err set.
- **Frame start**
  - If a bank is still FILLING: it goes to FREE and abort_cnt increments.
  - Then, if enable=1 and a FREE bank exists: the lowest-index FREE bank goes to FILLING and wr_bmp takes its one-hot value. A bank released in the same cycle is eligible.
  - Otherwise wr_bmp goes to 0 and drop_cnt increments.
- **Offer and grant**
  - res_valid = FIFO non-empty AND no bank READING. res_idx = FIFO head.
  - res_valid & res_ready: pop the head, that bank goes to READING, rd_bmp takes its one-hot value.
- **wr_bmp hold**
  - wr_bmp holds its value after core_eof until the next frame_start. The core stops writing after EOF, so this is harmless.
  - wr_bmp goes to 0 at core_eof only if enable=0.
- Counters saturate at all-ones. err clears only on reset.
- Reset mid-frame: all banks FREE, FIFO empty, outputs at reset values. The core sees wr_bmp=0 for the remainder of the frame.

## Timing
- Reset values:
  - wr_bmp, rd_bmp, res_idx: 0
  - res_valid, err: 0
  - all counters: 0
- frame_start at edge N: wr_bmp valid from N+1. The core samples wr_bmp four stages after the pixel, so there is margin.
- core_eof at edge N: the bank is FULL from N+1. res_valid is high in cycle N+1 if nothing is READING.
- res_valid is combinational from registered state.
  - Once asserted it stays high, with res_idx stable, until the handshake completes or reset.
  - res_ready is never required to be high.
- Handshake at edge N: rd_bmp valid from N+1. res_valid low from N+1 until release.
- res_release at edge N: rd_bmp = 0 from N+1. The next FIFO entry is offered from N+1.
- Bank throughput: release, eof and frame_start in the same cycle are all honoured.

## Test plan
- **Basic flow:** BR_NUM=4, enable=1, 3 frames of frame_start…core_eof, reader always ready and releasing 5 cycles after grant → wr_bmp sequence 0001, 0010, 0001 (bank 0 reused); res_idx 0, 1, 0; frame_cnt=3.
- **All banks full:** 5 frames with the reader stalled (res_ready=0) → banks 0–3 FULL, the 5th frame sees wr_bmp=0000, drop_cnt=1; after grants the banks arrive in order 0, 1, 2, 3.
- **Abort:** frame_start, then a second frame_start with no core_eof → bank 0 returns to FREE, abort_cnt=1, wr_bmp=0001 again, res_valid stays 0.
- **Same-cycle events:** only bank 2 free and bank 3 READING, then res_release + core_eof + frame_start in one cycle → filling bank becomes FULL, bank 2 allocated (lowest free, 0100), err=0.
- **Protocol errors:** core_eof with no FILLING bank → err=1, counters unchanged; res_release with rd_bmp=0 → err stays 1.
- **Asynchronous reset:** assert reset mid-READING without a clock edge → all outputs are at reset values immediately; after deassertion a new frame gets wr_bmp=0001.

Source files
------------

// File: rtl/fsa_bank_ctl.sv
// ---------------------------------------------------------------------------
// fsa_bank_ctl
//
// Bank scheduler for the frame-statistics line-buffer banks. At every frame
// start it claims the lowest-index FREE bank for the statistics core to
// write. Completed banks are queued in frame order and offered one at a time
// to the result reader through a valid/ready grant and a release pulse.
//
// Bank life cycle: FREE -> FILLING -> FULL -> READING -> FREE.
// At most one bank is FILLING and at most one is READING at any time.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   enable          allow a new bank allocation at frame start
//   frame_start     one-cycle pulse on the first accepted pixel of a frame
//   core_eof        one-cycle pulse when the core has written the last pixel
//   wr_bmp          one-hot write-bank select (all-zero: frame not captured)
//   res_valid       a FULL bank is offered (index on res_idx)
//   res_idx         index of the offered bank, zero while res_valid is low
//   res_ready       reader accepts the offered bank
//   rd_bmp          one-hot bank currently being read
//   res_release     reader has finished with the READING bank
//   frame_cnt       frames captured (saturating)
//   drop_cnt        frames not captured (saturating)
//   abort_cnt       FILLING banks discarded by an early frame start
//   err             sticky protocol error flag
// ---------------------------------------------------------------------------
module fsa_bank_ctl #(
  parameter int BR_NUM  = 4,
  parameter int BR_IW   = 2,
  parameter int C_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               core_eof,
  output logic [BR_NUM-1:0]  wr_bmp,
  output logic               res_valid,
  output logic [BR_IW-1:0]   res_idx,
  input  logic               res_ready,
  output logic [BR_NUM-1:0]  rd_bmp,
  input  logic               res_release,
  output logic [C_CNT_W-1:0] frame_cnt,
  output logic [C_CNT_W-1:0] drop_cnt,
  output logic [C_CNT_W-1:0] abort_cnt,
  output logic               err
);

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_st_e;

  localparam logic [BR_IW-1:0]   LAST_PTR = BR_IW'(BR_NUM - 1);
  localparam logic [C_CNT_W-1:0] CNT_MAX  = {C_CNT_W{1'b1}};

  // One-hot select for a bank index.
  function automatic logic [BR_NUM-1:0] idx_to_bmp(input logic [BR_IW-1:0] idx);
    return {{(BR_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [BR_IW-1:0] ptr_inc(input logic [BR_IW-1:0] p);
    return (p == LAST_PTR) ? {BR_IW{1'b0}} : p + BR_IW'(1);
  endfunction

  // Saturating counter increment.
  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + C_CNT_W'(1);
  endfunction

  // Registered state
  bank_st_e           bank_q [BR_NUM];
  bank_st_e           bank_d [BR_NUM];
  logic [BR_IW-1:0]   fifo_q [BR_NUM];
  logic [BR_IW-1:0]   fifo_d [BR_NUM];
  logic [BR_IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [BR_IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BR_IW:0]     cnt_q, cnt_d;
  logic [BR_NUM-1:0]  wr_bmp_q, wr_bmp_d;
  logic [BR_NUM-1:0]  rd_bmp_q, rd_bmp_d;
  logic [C_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [C_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [C_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic               err_q, err_d;

  // Combinational helpers
  logic               fill_found;
  logic [BR_IW-1:0]   fill_idx;
  logic               read_found;
  logic [BR_IW-1:0]   read_idx;
  logic               free_found;
  logic [BR_IW-1:0]   free_idx;
  logic [BR_IW-1:0]   head_idx;
  logic               grant;
  logic               push;
  logic               pop;

  // Locate the FILLING and READING banks in the registered state.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = {BR_IW{1'b0}};
    read_found = 1'b0;
    read_idx   = {BR_IW{1'b0}};
    for (int i = 0; i < BR_NUM; i++) begin
      fill_found = fill_found | (bank_q[i] == B_FILLING);
      fill_idx   = (bank_q[i] == B_FILLING) ? BR_IW'(i) : fill_idx;
      read_found = read_found | (bank_q[i] == B_READING);
      read_idx   = (bank_q[i] == B_READING) ? BR_IW'(i) : read_idx;
    end
  end

  assign head_idx  = fifo_q[rd_ptr_q];
  assign res_valid = (cnt_q != {(BR_IW+1){1'b0}}) && !read_found;
  assign res_idx   = res_valid ? head_idx : {BR_IW{1'b0}};
  assign grant     = res_valid & res_ready;

  // Next-state: release, grant, eof and frame start applied in that order.
  always_comb begin
    bank_d      = bank_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    wr_bmp_d    = wr_bmp_q;
    rd_bmp_d    = rd_bmp_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    abort_cnt_d = abort_cnt_q;
    err_d       = err_q;
    push        = 1'b0;
    pop         = 1'b0;
    free_found  = 1'b0;
    free_idx    = {BR_IW{1'b0}};

    if (res_release) begin
      if (read_found) begin
        bank_d[read_idx] = B_FREE;
        rd_bmp_d         = {BR_NUM{1'b0}};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      rd_bmp_d = rd_bmp_q;
    end

    // A grant needs no READING bank, so it never collides with a release.
    if (grant) begin
      bank_d[head_idx] = B_READING;
      rd_bmp_d         = idx_to_bmp(head_idx);
      rd_ptr_d         = ptr_inc(rd_ptr_q);
      pop              = 1'b1;
    end else begin
      pop = 1'b0;
    end

    if (core_eof) begin
      if (fill_found) begin
        bank_d[fill_idx] = B_FULL;
        fifo_d[wr_ptr_q] = fill_idx;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        push             = 1'b1;
        frame_cnt_d      = sat_inc(frame_cnt_q);
        // The core has stopped writing; only drop the select when disabled.
        wr_bmp_d         = enable ? wr_bmp_q : {BR_NUM{1'b0}};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      push = 1'b0;
    end

    if (frame_start) begin
      // A bank that completed on this same cycle is already FULL.
      if (fill_found && !core_eof) begin
        bank_d[fill_idx] = B_FREE;
        abort_cnt_d      = sat_inc(abort_cnt_q);
      end else begin
        abort_cnt_d = abort_cnt_q;
      end
      // Descending scan leaves the lowest FREE index; sees this cycle's release/abort.
      for (int i = BR_NUM - 1; i >= 0; i--) begin
        free_found = free_found | (bank_d[i] == B_FREE);
        free_idx   = (bank_d[i] == B_FREE) ? BR_IW'(i) : free_idx;
      end
      if (enable && free_found) begin
        bank_d[free_idx] = B_FILLING;
        wr_bmp_d         = idx_to_bmp(free_idx);
      end else begin
        wr_bmp_d   = {BR_NUM{1'b0}};
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
    end else begin
      free_found = 1'b0;
    end

    cnt_d = cnt_q + {{BR_IW{1'b0}}, push} - {{BR_IW{1'b0}}, pop};
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BR_NUM; i++) begin
        bank_q[i] <= B_FREE;
        fifo_q[i] <= {BR_IW{1'b0}};
      end
      rd_ptr_q    <= {BR_IW{1'b0}};
      wr_ptr_q    <= {BR_IW{1'b0}};
      cnt_q       <= {(BR_IW+1){1'b0}};
      wr_bmp_q    <= {BR_NUM{1'b0}};
      rd_bmp_q    <= {BR_NUM{1'b0}};
      frame_cnt_q <= {C_CNT_W{1'b0}};
      drop_cnt_q  <= {C_CNT_W{1'b0}};
      abort_cnt_q <= {C_CNT_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < BR_NUM; i++) begin
        bank_q[i] <= bank_d[i];
        fifo_q[i] <= fifo_d[i];
      end
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      wr_bmp_q    <= wr_bmp_d;
      rd_bmp_q    <= rd_bmp_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      err_q       <= err_d;
    end
  end

  assign wr_bmp    = wr_bmp_q;
  assign rd_bmp    = rd_bmp_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign abort_cnt = abort_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fsa_bank_ctl.sv
// ---------------------------------------------------------------------------
// tb_fsa_bank_ctl
//
// Directed bench for fsa_bank_ctl. Stimulus pushes the expected bank index
// of every completed frame into a queue; a separate monitor pops and
// compares on every res_valid & res_ready handshake. Status outputs are
// checked directly against hand-computed values after each step.
// ---------------------------------------------------------------------------
module tb_fsa_bank_ctl;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          enable      = 1'b0;
  logic          frame_start = 1'b0;
  logic          core_eof    = 1'b0;
  logic          res_ready   = 1'b0;
  logic          res_release = 1'b0;
  logic [N-1:0]  wr_bmp;
  logic [N-1:0]  rd_bmp;
  logic          res_valid;
  logic [IW-1:0] res_idx;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] abort_cnt;
  logic          err;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_exp;

  fsa_bank_ctl #(.BR_NUM(N), .BR_IW(IW), .C_CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_start(frame_start),
    .core_eof   (core_eof),
    .wr_bmp     (wr_bmp),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_ready  (res_ready),
    .rd_bmp     (rd_bmp),
    .res_release(res_release),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .abort_cnt  (abort_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must deliver the oldest expected bank.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected actual=%0d required=none", res_idx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("grant_idx", 32'(res_idx), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_eof();
    core_eof = 1'b1;
    tick();
    core_eof = 1'b0;
  endtask

  task automatic pulse_rel();
    res_release = 1'b1;
    tick();
    res_release = 1'b0;
  endtask

  task automatic do_reset();
    frame_start = 1'b0;
    core_eof    = 1'b0;
    res_release = 1'b0;
    res_ready   = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_bmp"},    32'(wr_bmp),    32'd0);
    check({tag, "_rd_bmp"},    32'(rd_bmp),    32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_idx"},   32'(res_idx),   32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
    check({tag, "_abort_cnt"}, 32'(abort_cnt), 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    check_reset("rst_hold");
    reset = 1'b0;
    tick();
    check_reset("rst_idle");

    // Basic flow: reader always ready, release 5 cycles after grant
    enable    = 1'b1;
    res_ready = 1'b1;
    pulse_fs();
    check("basic_wr0", 32'(wr_bmp), 32'h1);
    tick();
    tick();
    exp_q.push_back(2'd0);
    pulse_eof();
    check("basic_wr_hold", 32'(wr_bmp), 32'h1);
    check("basic_valid0", 32'(res_valid), 32'd1);
    tick();                                   // grant bank 0
    check("basic_rd0", 32'(rd_bmp), 32'h1);
    check("basic_valid_busy", 32'(res_valid), 32'd0);
    pulse_fs();
    check("basic_wr1", 32'(wr_bmp), 32'h2);
    tick();
    exp_q.push_back(2'd1);
    pulse_eof();
    tick();
    pulse_rel();
    check("basic_rd_clr", 32'(rd_bmp), 32'd0);
    check("basic_offer1", 32'(res_idx), 32'd1);
    tick();                                   // grant bank 1
    check("basic_rd1", 32'(rd_bmp), 32'h2);
    pulse_fs();
    check("basic_wr2", 32'(wr_bmp), 32'h1);
    tick();
    exp_q.push_back(2'd0);
    pulse_eof();
    tick();
    pulse_rel();
    tick();                                   // grant bank 0
    check("basic_rd2", 32'(rd_bmp), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    pulse_rel();
    check("basic_frame_cnt", 32'(frame_cnt), 32'd3);
    check("basic_idle_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // All banks full with a stalled reader, then same-cycle events
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < N; b++) begin
      pulse_fs();
      check("full_wr", 32'(wr_bmp), 32'h1 << b);
      exp_q.push_back(IW'(b));
      pulse_eof();
    end
    pulse_fs();
    check("full_drop_wr", 32'(wr_bmp), 32'd0);
    check("full_drop_cnt", 32'(drop_cnt), 32'd1);
    check("full_frame_cnt", 32'(frame_cnt), 32'd4);
    check("full_offer0", 32'(res_idx), 32'd0);
    for (int k = 0; k < N; k++) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("full_rd", 32'(rd_bmp), 32'h1 << k);
      if (k < N - 1) pulse_rel();
    end
    pulse_fs();
    check("same_wr0", 32'(wr_bmp), 32'h1);
    exp_q.push_back(2'd0);
    pulse_eof();
    pulse_fs();
    check("same_wr1", 32'(wr_bmp), 32'h2);
    exp_q.push_back(2'd1);
    res_release = 1'b1;
    core_eof    = 1'b1;
    frame_start = 1'b1;
    tick();
    res_release = 1'b0;
    core_eof    = 1'b0;
    frame_start = 1'b0;
    check("same_wr2", 32'(wr_bmp), 32'h4);
    check("same_rd", 32'(rd_bmp), 32'd0);
    check("same_err", 32'(err), 32'd0);
    check("same_frame_cnt", 32'(frame_cnt), 32'd6);
    check("same_abort", 32'(abort_cnt), 32'd0);
    check("same_offer", 32'(res_idx), 32'd0);
    check("same_valid", 32'(res_valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      pulse_rel();
    end

    // Abort: second frame start before core_eof
    do_reset();
    enable = 1'b1;
    pulse_fs();
    check("abort_wr0", 32'(wr_bmp), 32'h1);
    tick();
    tick();
    pulse_fs();
    check("abort_wr1", 32'(wr_bmp), 32'h1);
    check("abort_cnt", 32'(abort_cnt), 32'd1);
    check("abort_drop", 32'(drop_cnt), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    check("abort_valid", 32'(res_valid), 32'd0);

    // Protocol errors
    do_reset();
    enable = 1'b1;
    pulse_eof();
    check("perr_eof_err", 32'(err), 32'd1);
    check("perr_eof_frame", 32'(frame_cnt), 32'd0);
    check("perr_eof_drop", 32'(drop_cnt), 32'd0);
    pulse_rel();
    check("perr_rel_err", 32'(err), 32'd1);
    check("perr_rel_rd", 32'(rd_bmp), 32'd0);
    pulse_fs();
    check("perr_wr", 32'(wr_bmp), 32'h1);
    enable = 1'b0;
    exp_q.push_back(2'd0);
    pulse_eof();
    check("eof_dis_wr", 32'(wr_bmp), 32'd0);
    check("eof_dis_frame", 32'(frame_cnt), 32'd1);
    enable = 1'b1;

    // Asynchronous reset while a bank is READING
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("async_pre_rd", 32'(rd_bmp), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset("async");
    tick();
    reset = 1'b0;
    tick();
    pulse_fs();
    check("async_post_wr", 32'(wr_bmp), 32'h1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
